// File: rtl/store_unit_if.sv
// store_unit_if: store request, load probe and memory write bus of the store unit
// Master side (execute stage / memory) drives st_valid, st_op, st_addr, st_data,
// is_load, ld_addr; slave side (store_unit) drives st_ready, st_err, ld_hazard,
// we, w_addr, w_data.
interface store_unit_if;
    logic        st_valid;
    logic        st_ready;
    logic [1:0]  st_op;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_err;
    logic        is_load;
    logic [31:0] ld_addr;
    logic        ld_hazard;
    logic [3:0]  we;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    modport master (
        output st_valid, st_op, st_addr, st_data, is_load, ld_addr,
        input  st_ready, st_err, ld_hazard, we, w_addr, w_data
    );
    modport slave (
        input  st_valid, st_op, st_addr, st_data, is_load, ld_addr,
        output st_ready, st_err, ld_hazard, we, w_addr, w_data
    );
endinterface

// File: rtl/store_unit.sv
// store_unit: formats SB/SH/SW into byte lanes and drains them through an in-order store buffer
// Ports: clk, rst (async, active-high); bus (store_unit_if.slave): store handshake,
// load probe (is_load/ld_addr/ld_hazard) and masked memory write (we/w_addr/w_data);
// empty, count: buffer occupancy.
// Optional: define STORE_HAZARD_EN to build the load-vs-buffer word comparators.
module store_unit #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    store_unit_if.slave              bus,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    typedef struct packed {
        logic [4:0]  w_addr;
        logic [3:0]  we;
        logic [31:0] w_data;
    } entry_t;
    entry_t        mem_q [DEPTH];
    entry_t        head_e;
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [AW:0]   count_q, count_d;
    logic          err_q, err_d;
    logic [1:0]    off;
    logic          bad, push, pop;
    logic [3:0]    f_we;
    logic [31:0]   f_data;
    logic          unused_bits;
    always_comb begin
        off    = bus.st_addr[1:0];
        bad    = bus.st_op == 2'b11 || (bus.st_op == 2'b01 && off == 2'd3) ||
                 (bus.st_op == 2'b10 && off != 2'd0);
        // Lane 0 sits at [31:24], so shifting right by 8*off moves data to lane off.
        f_we   = bus.st_op == 2'b00 ? 4'b1000 >> off :
                 bus.st_op == 2'b01 ? 4'b1100 >> off : 4'b1111;
        f_data = bus.st_op == 2'b00 ? {bus.st_data[7:0], 24'd0} >> {off, 3'd0} :
                 bus.st_op == 2'b01 ? {bus.st_data[7:0], bus.st_data[15:8], 16'd0} >> {off, 3'd0} :
                 {bus.st_data[7:0], bus.st_data[15:8], bus.st_data[23:16], bus.st_data[31:24]};
        empty  = count_q == '0;
        push   = bus.st_valid && bus.st_ready && !bad;
        pop    = !empty && !bus.is_load;
        head_d = head_q + AW'(pop);
        tail_d = tail_q + AW'(push);
        count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
        err_d  = bus.st_valid && bus.st_ready && bad;
        head_e = mem_q[head_q];
    end
    assign bus.st_ready = count_q != (AW+1)'(DEPTH);
    assign bus.st_err   = err_q;
    assign bus.we       = pop ? head_e.we : 4'd0;
    assign bus.w_addr   = empty ? 5'd0 : head_e.w_addr;
    assign bus.w_data   = empty ? 32'd0 : head_e.w_data;
    assign count        = count_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end
    // Entry storage needs no reset: reads are masked by empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[tail_q] <= '{w_addr: bus.st_addr[6:2], we: f_we, w_data: f_data};
    end
`ifdef STORE_HAZARD_EN
    logic          hit;
    logic [AW-1:0] rel;
    always_comb begin
        hit = 1'b0;
        rel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            // Entry i is live when its distance from head is below count.
            rel = AW'(i) - head_q;
            if ({1'b0, rel} < count_q && mem_q[i].w_addr == bus.ld_addr[6:2]) hit = 1'b1;
        end
    end
    assign bus.ld_hazard = bus.is_load && hit;
    assign unused_bits   = ^{bus.st_addr[31:7], bus.ld_addr[31:7], bus.ld_addr[1:0]};
`else
    assign bus.ld_hazard = 1'b0;
    assign unused_bits   = ^{bus.st_addr[31:7], bus.ld_addr};
`endif
endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit: directed self-checking bench for store_unit (DEPTH=4)
module tb_store_unit;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       empty;
    logic [2:0] count;
    int         checks = 0;
    int         errors = 0;
`ifdef STORE_HAZARD_EN
    localparam logic HZ = 1'b1;
`else
    localparam logic HZ = 1'b0;
`endif
    store_unit_if bus ();
    store_unit #(.DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus), .empty(empty), .count(count));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
        bus.st_valid = v;
        bus.st_op    = op;
        bus.st_addr  = a;
        bus.st_data  = d;
    endtask
    initial begin
        drive(1'b0, 2'b00, 32'd0, 32'd0);
        bus.is_load = 1'b0;
        bus.ld_addr = 32'd0;
        @(negedge clk);
        check("rst_empty", empty, 1);
        check("rst_count", count, 0);
        check("rst_ready", bus.st_ready, 1);
        check("rst_we", bus.we, 0);
        check("rst_waddr", bus.w_addr, 0);
        check("rst_wdata", bus.w_data, 0);
        check("rst_err", bus.st_err, 0);
        check("rst_hz", bus.ld_hazard, 0);
        rst = 1'b0;
        // SW word 2
        @(negedge clk);
        drive(1'b1, 2'b10, 32'h08, 32'h11223344);
        @(negedge clk);
        drive(1'b0, 2'b00, 32'd0, 32'd0);
        check("sw_we", bus.we, 4'b1111);
        check("sw_waddr", bus.w_addr, 2);
        check("sw_wdata", bus.w_data, 32'h44332211);
        check("sw_count", count, 1);
        @(negedge clk);
        check("sw_empty", empty, 1);
        check("sw_we_after", bus.we, 0);
        // SB then SH back to back
        drive(1'b1, 2'b00, 32'h0D, 32'h000000AB);
        @(negedge clk);
        drive(1'b1, 2'b01, 32'h12, 32'h0000BEEF);
        check("sb_we", bus.we, 4'b0100);
        check("sb_waddr", bus.w_addr, 3);
        check("sb_wdata", bus.w_data, 32'h00AB0000);
        @(negedge clk);
        drive(1'b0, 2'b00, 32'd0, 32'd0);
        check("sh_we", bus.we, 4'b0011);
        check("sh_waddr", bus.w_addr, 4);
        check("sh_wdata", bus.w_data, 32'h0000EFBE);
        check("sh_count", count, 1);
        @(negedge clk);
        check("sbsh_empty", empty, 1);
        // Misaligned SW and SH
        drive(1'b1, 2'b10, 32'h06, 32'hDEADBEEF);
        check("mis_ready", bus.st_ready, 1);
        check("mis_err_pre", bus.st_err, 0);
        @(negedge clk);
        drive(1'b1, 2'b01, 32'h03, 32'h00001234);
        check("mis_sw_err", bus.st_err, 1);
        check("mis_sw_count", count, 0);
        check("mis_sw_we", bus.we, 0);
        @(negedge clk);
        drive(1'b0, 2'b00, 32'd0, 32'd0);
        check("mis_sh_err", bus.st_err, 1);
        check("mis_sh_count", count, 0);
        check("mis_sh_we", bus.we, 0);
        @(negedge clk);
        check("mis_err_clear", bus.st_err, 0);
        check("mis_empty", empty, 1);
        // Reserved op
        drive(1'b1, 2'b11, 32'h00, 32'h1);
        @(negedge clk);
        drive(1'b0, 2'b00, 32'd0, 32'd0);
        check("rsv_err", bus.st_err, 1);
        check("rsv_count", count, 0);
        // Fill under load: five SB pushes, only four fit
        bus.is_load = 1'b1;
        bus.ld_addr = 32'h40;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 2'b00, 32'(4 * i + 1), 32'(8'h10 + i));
            check("fill_ready", bus.st_ready, i < 4);
            check("fill_we", bus.we, 0);
            @(negedge clk);
        end
        drive(1'b0, 2'b00, 32'd0, 32'd0);
        check("full_count", count, 4);
        check("full_ready", bus.st_ready, 0);
        check("full_hz_miss", bus.ld_hazard, 0);
        bus.ld_addr = 32'h0B;
        #1;
        check("full_hz_hit", bus.ld_hazard, HZ);
        bus.is_load = 1'b0;
        #1;
        check("full_ready_pop", bus.st_ready, 0);
        for (int i = 0; i < 4; i++) begin
            check("drain_we", bus.we, 4'b0100);
            check("drain_waddr", bus.w_addr, i);
            check("drain_wdata", bus.w_data, 32'(8'h10 + i) << 16);
            @(negedge clk);
        end
        check("drain_empty", empty, 1);
        check("drain_we_end", bus.we, 0);
        // Hazard on word 5
        bus.is_load = 1'b1;
        drive(1'b1, 2'b10, 32'h14, 32'hCAFEF00D);
        @(negedge clk);
        drive(1'b0, 2'b00, 32'd0, 32'd0);
        bus.ld_addr = 32'h14;
        #1;
        check("hz_word5", bus.ld_hazard, HZ);
        bus.ld_addr = 32'h18;
        #1;
        check("hz_word6", bus.ld_hazard, 0);
        check("hz_stall_we", bus.we, 0);
        check("hz_hold_waddr", bus.w_addr, 5);
        bus.is_load = 1'b0;
        #1;
        check("hz_noload", bus.ld_hazard, 0);
        check("hz_drain_we", bus.we, 4'b1111);
        check("hz_drain_wdata", bus.w_data, 32'h0DF0FECA);
        @(negedge clk);
        check("hz_empty", empty, 1);
        // Reset mid-drain with three entries
        bus.is_load = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'b00, 32'(32'h20 + 4 * i + 3), 32'(8'h50 + i));
            @(negedge clk);
        end
        drive(1'b0, 2'b00, 32'd0, 32'd0);
        check("rd_count", count, 3);
        bus.is_load = 1'b0;
        #1;
        check("rd_we", bus.we, 4'b0001);
        check("rd_waddr", bus.w_addr, 8);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rd_rst_we", bus.we, 0);
        check("rd_rst_waddr", bus.w_addr, 0);
        check("rd_rst_wdata", bus.w_data, 0);
        check("rd_rst_empty", empty, 1);
        check("rd_rst_count", count, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_we", bus.we, 0);
            check("post_rst_empty", empty, 1);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/store_unit.md
# store_unit

Store-side companion to the data memory's load path. It accepts SB/SH/SW requests from the execute stage over a valid/ready handshake and places each byte in the memory's byte-lane layout. Accepted stores are held in a small in-order store buffer. Each store drains as one masked write (`we`, `w_addr`, `w_data`) in any cycle the memory is not serving a load.

## Interface
Parameters:
- `DEPTH`, default 4: store buffer entries; power of two, 2..16.

Ports:
- `clk` in, 1 bit: clock; all state updates on the rising edge.
- `rst` in, 1 bit: asynchronous, active-high reset.
- `st_valid` in, 1 bit: a store request is present.
- `st_ready` out, 1 bit: the buffer can accept; equals `!full`.
- `st_op` in, 2 bits: 00 SB, 01 SH, 10 SW, 11 reserved.
- `st_addr` in, 32 bits: byte address; only [6:0] is used.
- `st_data` in, 32 bits: store data, right-aligned.
- `st_err` out, 1 bit: one-cycle pulse after a rejected store.
- `is_load` in, 1 bit: the memory is serving a load this cycle.
- `ld_addr` in, 32 bits: the load's byte address; only [6:2] is used.
- `ld_hazard` out, 1 bit: the load word matches a buffered store.
- `we` out, 4 bits: byte write enables to the memory.
- `w_addr` out, 5 bits: memory word index.
- `w_data` out, 32 bits: lane-formatted write data.
- `empty` out, 1 bit: the buffer holds no entries.
- `count` out, $clog2(DEPTH)+1 bits: number of occupied entries.

## Operation
- Word index is `st_addr[6:2]`; byte offset `off` is `st_addr[1:0]`.
- Lane map: `off` 0 is bits [31:24], 1 is [23:16], 2 is [15:8], 3 is [7:0]. Byte order is little-endian within a word.
- SB:
  - `data[7:0]` goes to lane `off`; only that lane's `we` bit is set.
  - `we`: off0 1000, off1 0100, off2 0010, off3 0001.
- SH, offsets 0..2:
  - `data[7:0]` goes to lane `off`; `data[15:8]` goes to lane `off+1`.
  - `we`: off0 1100, off1 0110, off2 0011.
  - SH at `off` 3 is misaligned.
- SW, `off` 0 only:
  - lanes: `data[7:0]` to [31:24], `[15:8]` to [23:16], `[23:16]` to [15:8], `[31:24]` to [7:0].
  - `we` 1111.
  - SW at any other `off` is misaligned.
- Formatting happens at accept time. Each entry stores `{w_addr, we, w_data}`. Unselected lanes of `w_data` are 0.
- Rejected requests: misaligned stores and `st_op`=11.
  - They are consumed: handshake completes and the pipeline does not stall.
  - Nothing is written to the buffer.
  - `st_err` pulses for one cycle.
- Buffer is a FIFO with head/tail pointers that wrap modulo DEPTH.
- Drain:
  - When `!empty && !is_load`, the outputs show the head entry's `we`/`w_addr`/`w_data` combinationally, and the head pops at that edge.
  - Otherwise `we`=0; `w_addr` and `w_data` hold the head contents, or 0 when empty.
- Loads always take priority; a load cycle stalls the drain.
- Reset: pointers, `count`, and `st_err` go to 0; `empty`=1; `st_ready`=1; `we`=0; `w_addr`=0; `w_data`=0; `ld_hazard`=0. Buffer contents are discarded; in-flight stores are lost.

## Timing
- Accept: at an edge where `st_valid && st_ready`. The entry is visible at head/`count` after that edge.
- Minimum latency from accept to `we` is 1 cycle, when the buffer was empty and `is_load`=0.
- Throughput: one accept and one drain per cycle. Simultaneous push and pop leaves `count` unchanged.
- Full: `st_ready`=0 even if a pop occurs in the same cycle. Push is not allowed on a full buffer.
- `st_err` is registered: it asserts the cycle after the rejected handshake.
- `ld_hazard` is combinational in the same cycle as `is_load`.
- Rejected stores never change `count`.

## Configuration
- `STORE_HAZARD_EN` defined:
  - `ld_hazard` = `is_load && (any valid entry's w_addr == ld_addr[6:2])`.
  - Valid entries include the head; the hazard ignores byte lanes.
  - The pipeline stalls the load until it clears.
- `STORE_HAZARD_EN` undefined: `ld_hazard` is tied to 0, no comparators are built, and ordering is the pipeline's responsibility.

## Test plan
- Reset, then SW addr 0x08 data 0x11223344, `is_load`=0: next cycle `we`=1111, `w_addr`=2, `w_data`=0x44332211; then `empty`=1.
- SB 0x0D data 0xAB, then SH 0x12 data 0xBEEF: first `we`=0100, `w_addr`=3, `w_data`=0x00AB0000; then `we`=0011, `w_addr`=4, `w_data`=0x0000EFBE.
- SW 0x06 and SH 0x03: each is accepted, `st_err` pulses one cycle later, `count` stays 0, and `we` is never asserted.
- `is_load`=1 held, DEPTH+1 SB pushes: `st_ready` falls once `count`=DEPTH. Release `is_load`: DEPTH writes drain in order, one per cycle.
- With `STORE_HAZARD_EN`: buffer SW to word 5, `is_load`=1, `ld_addr`=0x14 gives `ld_hazard`=1; `ld_addr`=0x18 gives 0. Without the macro, both give 0.
- Assert `rst` mid-drain with 3 entries: outputs zero immediately, `empty`=1, and no further `we` after release.
